// File: rtl/riscv_dp_lsu_ctrl_if.sv
// Execute-stage request and data-memory port signals of the LSU controller.
// slave = the controller, master = the pipeline/memory side driving it.
interface riscv_dp_lsu_ctrl_if #(
  parameter int MP_DATA_WIDTH = 32,
  parameter int MP_ADDR_WIDTH = 32
);
  logic                     ireq_valid;
  logic                     oreq_ready;
  logic                     ireq_we;
  logic [2:0]               ifunct3;
  logic [MP_ADDR_WIDTH-1:0] iaddr;
  logic [MP_DATA_WIDTH-1:0] iwdata;
  logic                     odone;
  logic [MP_DATA_WIDTH-1:0] ordata;
  logic                     oerr;
  logic                     omem_req;
  logic                     imem_gnt;
  logic                     omem_we;
  logic [MP_ADDR_WIDTH-1:0] omem_addr;
  logic [3:0]               omem_be;
  logic [MP_DATA_WIDTH-1:0] omem_wdata;
  logic                     imem_rvalid;
  logic [MP_DATA_WIDTH-1:0] imem_rdata;

  modport slave (
    input  ireq_valid, ireq_we, ifunct3, iaddr, iwdata, imem_gnt, imem_rvalid, imem_rdata,
    output oreq_ready, odone, ordata, oerr, omem_req, omem_we, omem_addr, omem_be, omem_wdata
  );

  modport master (
    output ireq_valid, ireq_we, ifunct3, iaddr, iwdata, imem_gnt, imem_rvalid, imem_rdata,
    input  oreq_ready, odone, ordata, oerr, omem_req, omem_we, omem_addr, omem_be, omem_wdata
  );
endinterface

// File: rtl/riscv_dp_lsu_ctrl.sv
// Load/store controller: one access at a time onto a req/gnt/rvalid memory port,
// splitting word-crossing accesses into two word beats.
//   state  | meaning
//   IDLE   | ready for a new access
//   REQ0   | first (or only) beat requested, waiting for grant
//   WAIT0  | first read beat granted, waiting for rvalid
//   REQ1   | second beat of a split access requested
//   WAIT1  | second read beat granted, waiting for rvalid
//   DONE   | completion pulse, result/err valid
module riscv_dp_lsu_ctrl #(
  parameter int MP_DATA_WIDTH = 32,
  parameter int MP_ADDR_WIDTH = 32
) (
  input logic                  iclk,
  input logic                  irstn,
  riscv_dp_lsu_ctrl_if.slave   lsu
);
  localparam int DW = MP_DATA_WIDTH;
  localparam int AW = MP_ADDR_WIDTH;

  typedef enum logic [2:0] {S_IDLE, S_REQ0, S_WAIT0, S_REQ1, S_WAIT1, S_DONE} state_t;

  state_t          r_state;
  logic            r_we;
  logic [2:0]      r_funct3;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_wdata;
  logic [DW-1:0]   r_lo;

  logic            w_we;
  logic [2:0]      w_f3;
  logic [AW-1:0]   w_addr;
  logic [DW-1:0]   w_wdata;
  logic [AW-1:0]   w_base;
  logic [AW-1:0]   w_base1;
  logic [1:0]      w_off;
  logic [2:0]      w_size;
  logic [7:0]      w_mask_raw;
  logic [7:0]      w_mask;
  logic            w_split;
  logic            w_legal;
  logic [63:0]     w_data64;
  logic [DW-1:0]   w_lo;
  logic [DW-1:0]   w_hi;
  logic [63:0]     w_merged;
  logic [DW-1:0]   w_ext;

  // In IDLE the beat fields are derived from the incoming request so they can be
  // registered on the accepting edge; afterwards from the latched copy.
  always_comb begin
    w_we    = r_we;
    w_f3    = r_funct3;
    w_addr  = r_addr;
    w_wdata = r_wdata;
    if (r_state == S_IDLE) begin
      w_we    = lsu.ireq_we;
      w_f3    = lsu.ifunct3;
      w_addr  = lsu.iaddr;
      w_wdata = lsu.iwdata;
    end
    w_off   = w_addr[1:0];
    w_base  = {w_addr[AW-1:2], 2'b00};
    w_base1 = w_base + AW'(4);
    case (w_f3[1:0])
      2'b00:   begin w_size = 3'd1; w_mask_raw = 8'h01; end
      2'b01:   begin w_size = 3'd2; w_mask_raw = 8'h03; end
      default: begin w_size = 3'd4; w_mask_raw = 8'h0F; end
    endcase
    w_mask   = w_mask_raw << w_off;
    w_split  = ({1'b0, w_off} + w_size) > 3'd4;
    w_data64 = {{(64-DW){1'b0}}, w_wdata} << {w_off, 3'b000};
    if (w_we) w_legal = w_f3 inside {3'b000, 3'b001, 3'b010};
    else      w_legal = w_f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    w_lo = r_lo;
    w_hi = '0;
    if (r_state == S_WAIT0) w_lo = lsu.imem_rdata;
    else                    w_hi = lsu.imem_rdata;
    w_merged = {w_hi, w_lo} >> {r_addr[1:0], 3'b000};
    case (r_funct3)
      3'b000:  w_ext = {{(DW-8){w_merged[7]}}, w_merged[7:0]};
      3'b001:  w_ext = {{(DW-16){w_merged[15]}}, w_merged[15:0]};
      3'b010:  w_ext = w_merged[DW-1:0];
      3'b100:  w_ext = {{(DW-8){1'b0}}, w_merged[7:0]};
      3'b101:  w_ext = {{(DW-16){1'b0}}, w_merged[15:0]};
      default: w_ext = '0;
    endcase
  end

  always_ff @(posedge iclk or negedge irstn) begin
    if (!irstn) begin
      r_state        <= S_IDLE;
      r_we           <= 1'b0;
      r_funct3       <= '0;
      r_addr         <= '0;
      r_wdata        <= '0;
      r_lo           <= '0;
      lsu.oreq_ready <= 1'b1;
      lsu.odone      <= 1'b0;
      lsu.oerr       <= 1'b0;
      lsu.ordata     <= '0;
      lsu.omem_req   <= 1'b0;
      lsu.omem_we    <= 1'b0;
      lsu.omem_addr  <= '0;
      lsu.omem_be    <= '0;
      lsu.omem_wdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (lsu.ireq_valid) begin
            r_we           <= lsu.ireq_we;
            r_funct3       <= lsu.ifunct3;
            r_addr         <= lsu.iaddr;
            r_wdata        <= lsu.iwdata;
            lsu.oreq_ready <= 1'b0;
            if (w_legal) begin
              r_state        <= S_REQ0;
              lsu.omem_req   <= 1'b1;
              lsu.omem_we    <= w_we;
              lsu.omem_addr  <= w_base;
              lsu.omem_be    <= w_we ? w_mask[3:0] : 4'hF;
              lsu.omem_wdata <= w_we ? w_data64[31:0] : '0;
            end else begin
              r_state    <= S_DONE;
              lsu.odone  <= 1'b1;
              lsu.oerr   <= 1'b1;
              lsu.ordata <= '0;
            end
          end
        end
        S_REQ0, S_REQ1: begin
          if (lsu.imem_gnt) begin
            if (!r_we) begin
              lsu.omem_req <= 1'b0;
              r_state      <= (r_state == S_REQ0) ? S_WAIT0 : S_WAIT1;
            end else if (r_state == S_REQ0 && w_split) begin
              r_state        <= S_REQ1;
              lsu.omem_addr  <= w_base1;
              lsu.omem_be    <= w_mask[7:4];
              lsu.omem_wdata <= w_data64[63:32];
            end else begin
              lsu.omem_req <= 1'b0;
              r_state      <= S_DONE;
              lsu.odone    <= 1'b1;
            end
          end
        end
        S_WAIT0, S_WAIT1: begin
          if (lsu.imem_rvalid) begin
            if (r_state == S_WAIT0) r_lo <= lsu.imem_rdata;
            if (r_state == S_WAIT0 && w_split) begin
              r_state       <= S_REQ1;
              lsu.omem_req  <= 1'b1;
              lsu.omem_addr <= w_base1;
              lsu.omem_be   <= 4'hF;
            end else begin
              r_state    <= S_DONE;
              lsu.odone  <= 1'b1;
              lsu.ordata <= w_ext;
            end
          end
        end
        S_DONE: begin
          lsu.odone      <= 1'b0;
          lsu.oerr       <= 1'b0;
          lsu.oreq_ready <= 1'b1;
          r_state        <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
